// File: rtl/riscv_multicycle_controller.sv
// riscv_multicycle_controller
// Multi-cycle sequencer for an RV32I datapath. Each instruction walks through
// FETCH / DECODE / EXECUTE / (MEM) / (WRITEBACK) and the controller drives the
// datapath strobes, the shared memory handshake and a retired-instruction count.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   opcode            IR opcode field (valid from DECODE onward)
//   branch_taken      ALU compare result, used in EXECUTE for branches
//   mem_ready         memory completes the current request this cycle
//   mem_req, mem_we   memory request / write qualifier
//   ir_write          load instruction register
//   pc_write, pc_src  load PC; source 00 pc+4, 01 branch/jal target, 10 jalr
//   alu_src           1 = immediate as ALU operand B
//   reg_write         register file write enable
//   instr_done        one-cycle pulse per retired instruction
//   retired           retired-instruction count (wraps)
//   state_o, halted   debug state encoding, HALT indicator
//   bus_error         sticky memory-timeout flag
//   illegal_instr     sticky illegal-opcode flag (ILLEGAL_TRAP_EN builds only)
//
// Build option: define ILLEGAL_TRAP_EN to trap unsupported opcodes into HALT
// instead of retiring them as NOPs.
module riscv_multicycle_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src,
  output logic             reg_write,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state_o,
  output logic             halted,
`ifdef ILLEGAL_TRAP_EN
  output logic             illegal_instr,
`endif
  output logic             bus_error
);

  typedef enum logic [2:0] {
    RST_IDLE  = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEM       = 3'd4,
    WRITEBACK = 3'd5,
    HALT      = 3'd7
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  // Timeout fires on the wait cycle that would bring the count to MEM_TIMEOUT,
  // so a request that completes on that same cycle is never flagged.
  localparam int TO_W   = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int TO_LIM = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

  state_t          state, state_next;
  logic [6:0]      op_q;
  logic [TO_W-1:0] to_cnt;
  logic            timeout_hit;
  logic            dec_supported;

  function automatic logic is_supported(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE) ||
           (op == OP_BRANCH) || (op == OP_LUI) || (op == OP_AUIPC) ||
           (op == OP_JAL) || (op == OP_JALR);
  endfunction

  assign dec_supported = is_supported(opcode);
  assign timeout_hit   = (MEM_TIMEOUT > 0) && mem_req && !mem_ready &&
                         (to_cnt == TO_W'(TO_LIM));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= RST_IDLE;
    else     state <= state_next;
  end

  // Opcode is captured once in DECODE so later states do not depend on the IR
  always_ff @(posedge clk) begin
    if (state == DECODE) op_q <= opcode;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      RST_IDLE: state_next = FETCH;
      FETCH:    if (mem_ready) state_next = DECODE;
      DECODE: begin
        if (dec_supported) state_next = EXECUTE;
        else if (TRAP)     state_next = HALT;
        else               state_next = FETCH;
      end
      EXECUTE: begin
        if (op_q == OP_BRANCH)                           state_next = FETCH;
        else if ((op_q == OP_LOAD) || (op_q == OP_STORE)) state_next = MEM;
        else                                             state_next = WRITEBACK;
      end
      MEM: begin
        if (mem_ready) state_next = (op_q == OP_LOAD) ? WRITEBACK : FETCH;
      end
      WRITEBACK: state_next = FETCH;
      HALT:      state_next = HALT;
      default:   state_next = RST_IDLE;
    endcase
    if (timeout_hit) state_next = HALT;
  end

  // Output decode
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
      end
      DECODE: begin
        if (!dec_supported && !TRAP) instr_done = 1'b1;
      end
      EXECUTE: begin
        alu_src = !((op_q == OP_R) || (op_q == OP_BRANCH));
        if (op_q == OP_BRANCH) begin
          pc_write   = branch_taken;
          pc_src     = 2'b01;
          instr_done = 1'b1;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = (op_q == OP_STORE);
        if (mem_ready && (op_q == OP_STORE)) instr_done = 1'b1;
      end
      WRITEBACK: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        if (op_q == OP_JAL) begin
          pc_write = 1'b1;
          pc_src   = 2'b01;
        end else if (op_q == OP_JALR) begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
        end
      end
      default: ;
    endcase
  end

  assign state_o = state;
  assign halted  = (state == HALT);

  // Retire counter, timeout counter and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      retired   <= '0;
      bus_error <= 1'b0;
      to_cnt    <= '0;
    end else begin
      if (instr_done)  retired <= retired + CNT_W'(1);
      if (timeout_hit) bus_error <= 1'b1;
      if (mem_req && !mem_ready) to_cnt <= to_cnt + TO_W'(1);
      else                       to_cnt <= '0;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst)                                    illegal_instr <= 1'b0;
    else if ((state == DECODE) && !dec_supported) illegal_instr <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
module tb_riscv_multicycle_controller;

  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 15;
  localparam int RET_MOD     = 16;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [6:0]       opcode = '0;
  logic             branch_taken = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_req, mem_we, ir_write, pc_write, alu_src, reg_write;
  logic [1:0]       pc_src;
  logic             instr_done, halted, bus_error;
  logic [CNT_W-1:0] retired;
  logic [2:0]       state_o;
`ifdef ILLEGAL_TRAP_EN
  logic             illegal_instr;
`endif

  int checks = 0;
  int errors = 0;
  int exp_ret = 0;

  riscv_multicycle_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src(alu_src), .reg_write(reg_write), .instr_done(instr_done),
    .retired(retired), .state_o(state_o), .halted(halted),
`ifdef ILLEGAL_TRAP_EN
    .illegal_instr(illegal_instr),
`endif
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lat; int rw; int rw_last; int we; int req; int pcw; int xsrc; int alu;
    int irw; int fsrc; int done;
  } meas_t;

  typedef struct {
    logic [6:0] op; int fw; int mw; logic bt; meas_t e;
  } vec_t;

  vec_t tab[$];
  int   obs_st[64];
  int   exp_st[64];
  int   exp_len;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [6:0] op, input int fw, input int mw, input logic bt,
                         input int lat, input int rw, input int we, input int req,
                         input int pcw, input int xsrc, input int alu);
    vec_t v;
    v.op = op; v.fw = fw; v.mw = mw; v.bt = bt;
    v.e = '{lat, rw, rw, we, req, pcw, xsrc, alu, 1, 0, 1};
    tab.push_back(v);
  endtask

  // Instruction-level reference: phase list and strobe totals from the class rules
  task automatic model(input logic [6:0] op, input int fw, input int mw, input logic bt,
                       output meas_t e);
    bit br, ld, st, ls, jal, jalr, sup, wr;
    int n;
    br   = (op == OP_BRANCH);
    ld   = (op == OP_LOAD);
    st   = (op == OP_STORE);
    ls   = ld || st;
    jal  = (op == OP_JAL);
    jalr = (op == OP_JALR);
    sup  = (op == OP_R) || (op == OP_I) || ls || br || (op == OP_LUI) ||
           (op == OP_AUIPC) || jal || jalr;
    wr   = sup && !st && !br;
    n = 0;
    for (int k = 0; k <= fw; k++) begin exp_st[n] = 1; n++; end
    exp_st[n] = 2; n++;
    if (sup) begin
      exp_st[n] = 3; n++;
      if (ls) for (int k = 0; k <= mw; k++) begin exp_st[n] = 4; n++; end
      if (wr) begin exp_st[n] = 5; n++; end
    end
    exp_len   = n;
    e.lat     = n;
    e.rw      = wr ? 1 : 0;
    e.rw_last = wr ? 1 : 0;
    e.we      = st ? mw + 1 : 0;
    e.req     = fw + 1 + (ls ? mw + 1 : 0);
    e.pcw     = 1 + ((br && bt) ? 1 : 0) + ((jal || jalr) ? 1 : 0);
    e.xsrc    = ((br && bt) || jal) ? 1 : (jalr ? 2 : 3);
    e.alu     = (sup && (op != OP_R) && !br) ? 1 : 0;
    e.irw     = 1;
    e.fsrc    = 0;
    e.done    = 1;
  endtask

  // Runs one instruction starting in FETCH; memory answers after fw / mw waits
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input logic bt,
                           output meas_t m, output int ret_after);
    int phase, wc, w;
    phase = 0; wc = 0;
    m = '{default: 0};
    m.xsrc = 3;
    opcode = op;
    branch_taken = bt;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (mem_req) begin
        w = (phase == 0) ? fw : mw;
        mem_ready = (wc >= w);
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      obs_st[c] = int'(state_o);
      m.lat = c + 1;
      if (reg_write) m.rw++;
      if (mem_we)    m.we++;
      if (mem_req)   m.req++;
      if (pc_write)  m.pcw++;
      if (alu_src)   m.alu++;
      if (ir_write) begin
        m.irw++;
        if (pc_src != 2'b00) m.fsrc++;
      end
      if (pc_write && !ir_write) m.xsrc = int'(pc_src);
      if (mem_req) begin
        if (mem_ready) begin phase++; wc = 0; end
        else wc++;
      end
      if (instr_done || halted) begin
        m.rw_last = reg_write ? 1 : 0;
        m.done    = instr_done ? 1 : 0;
        break;
      end
    end
    @(posedge clk);
    #1;
    ret_after = int'(retired);
  endtask

  task automatic compare(input string tag, input meas_t m, input meas_t e, input int ret);
    int bad;
    chk({tag, " latency"}, m.lat, e.lat);
    chk({tag, " done"}, m.done, e.done);
    chk({tag, " reg_write cycles"}, m.rw, e.rw);
    chk({tag, " reg_write last"}, m.rw_last, e.rw_last);
    chk({tag, " mem_we cycles"}, m.we, e.we);
    chk({tag, " mem_req cycles"}, m.req, e.req);
    chk({tag, " pc_write cycles"}, m.pcw, e.pcw);
    chk({tag, " pc_src late"}, m.xsrc, e.xsrc);
    chk({tag, " alu_src cycles"}, m.alu, e.alu);
    chk({tag, " ir_write cycles"}, m.irw, e.irw);
    chk({tag, " fetch pc_src"}, m.fsrc, e.fsrc);
    bad = -1;
    if (m.lat != exp_len) bad = 99;
    else for (int k = 0; k < exp_len; k++)
      if ((bad < 0) && (obs_st[k] != exp_st[k])) bad = k;
    chk({tag, " state seq first bad idx"}, bad, -1);
    chk({tag, " retired"}, ret, exp_ret);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_ret = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    meas_t m, e;
    int ret, cnt, nwe, ndone;
    bit fetched;
`ifdef ILLEGAL_TRAP_EN
    logic [6:0] ops[9] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC,
                           OP_JAL, OP_JALR};
    int nops = 9;
`else
    logic [6:0] ops[10] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC,
                            OP_JAL, OP_JALR, OP_FENCE};
    int nops = 10;
`endif
    logic [6:0] rop;
    int rfw, rmw;
    logic rbt;

    //                op        fw  mw  bt   lat rw we req pcw xsrc alu
    add_vec(OP_R,      0,  0, 1'b0,  4, 1, 0,  1, 1, 3, 0);
    add_vec(OP_I,      0,  0, 1'b0,  4, 1, 0,  1, 1, 3, 1);
    add_vec(OP_LOAD,   0,  2, 1'b0,  7, 1, 0,  4, 1, 3, 1);
    add_vec(OP_STORE,  0,  0, 1'b0,  4, 0, 1,  2, 1, 3, 1);
    add_vec(OP_BRANCH, 0,  0, 1'b1,  3, 0, 0,  1, 2, 1, 0);
    add_vec(OP_BRANCH, 0,  0, 1'b0,  3, 0, 0,  1, 1, 3, 0);
    add_vec(OP_JALR,   0,  0, 1'b0,  4, 1, 0,  1, 2, 2, 1);
    add_vec(OP_JAL,    0,  0, 1'b0,  4, 1, 0,  1, 2, 1, 1);
    add_vec(OP_LUI,    2,  0, 1'b0,  6, 1, 0,  3, 1, 3, 1);
    add_vec(OP_AUIPC,  0,  0, 1'b1,  4, 1, 0,  1, 1, 3, 1);
    add_vec(OP_STORE,  1,  3, 1'b0,  8, 0, 4,  6, 1, 3, 1);
    add_vec(OP_LOAD,  14, 14, 1'b0, 33, 1, 0, 30, 1, 3, 1);
`ifndef ILLEGAL_TRAP_EN
    add_vec(OP_FENCE,  0,  0, 1'b0,  2, 0, 0,  1, 1, 3, 0);
`endif

    // Reset state
    do_reset();
    chk("reset state", int'(state_o), 0);
    chk("reset outputs", int'({mem_req, mem_we, ir_write, pc_write, pc_src, alu_src,
                               reg_write, instr_done, halted, bus_error}), 0);
    chk("reset retired", int'(retired), 0);

    // Table-driven instructions, back to back
    foreach (tab[i]) begin
      model(tab[i].op, tab[i].fw, tab[i].mw, tab[i].bt, e);
      run_instr(tab[i].op, tab[i].fw, tab[i].mw, tab[i].bt, m, ret);
      exp_ret = (exp_ret + 1) % RET_MOD;
      compare($sformatf("tab%0d", i), m, tab[i].e, ret);
    end
    chk("no bus_error after 14-wait accesses", int'(bus_error), 0);

    // Fetch timeout: 15 wait cycles then HALT with bus_error
    do_reset();
    opcode = OP_R;
    cnt = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      if ((state_o != 3'd1) || bus_error) cnt++;
    end
    chk("timeout fetch cycles before halt", cnt, 0);
    @(posedge clk);
    #1;
    chk("timeout state", int'(state_o), 7);
    chk("timeout halted", int'(halted), 1);
    chk("timeout bus_error", int'(bus_error), 1);
    chk("timeout mem_req", int'(mem_req), 0);
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      if (!halted || (state_o != 3'd7) || mem_req || instr_done) cnt++;
    end
    chk("halt is sticky", cnt, 0);
    do_reset();
    chk("post-halt reset state", int'(state_o), 0);
    chk("post-halt reset bus_error", int'(bus_error), 0);
    chk("post-halt reset halted", int'(halted), 0);
    model(OP_R, 0, 0, 1'b0, e);
    run_instr(OP_R, 0, 0, 1'b0, m, ret);
    exp_ret = (exp_ret + 1) % RET_MOD;
    compare("recover add", m, e, ret);

    // MEM timeout on a store: no retire, store strobe for the 15 wait cycles
    do_reset();
    opcode = OP_STORE;
    fetched = 1'b0;
    nwe = 0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mem_req && !fetched) begin mem_ready = 1'b1; fetched = 1'b1; end
      else mem_ready = 1'b0;
      #1;
      if (mem_we) nwe++;
      if (instr_done) ndone++;
      if (halted) break;
    end
    chk("mem timeout we cycles", nwe, 15);
    chk("mem timeout done pulses", ndone, 0);
    chk("mem timeout halted", int'(halted), 1);
    chk("mem timeout bus_error", int'(bus_error), 1);
    chk("mem timeout retired", int'(retired), 0);

    // Reset in the middle of a store handshake
    do_reset();
    model(OP_R, 0, 0, 1'b0, e);
    run_instr(OP_R, 0, 0, 1'b0, m, ret);
    chk("pre-abort retired", ret, 1);
    opcode = OP_STORE;
    @(negedge clk); mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("abort mid mem_we", int'(mem_we), 1);
    rst = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("abort state", int'(state_o), 0);
    chk("abort mem_we", int'(mem_we), 0);
    chk("abort retired", int'(retired), 0);
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b0;
    exp_ret = 0;

`ifdef ILLEGAL_TRAP_EN
    // Unsupported opcode traps into HALT
    do_reset();
    chk("illegal reset", int'(illegal_instr), 0);
    opcode = OP_FENCE;
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      mem_ready = mem_req;
      #1;
      if (instr_done) ndone++;
      if (halted) break;
    end
    chk("trap halted", int'(halted), 1);
    chk("trap illegal_instr", int'(illegal_instr), 1);
    chk("trap done pulses", ndone, 0);
    chk("trap retired", int'(retired), 0);
`endif

    // Randomized instruction stream against the reference model
    do_reset();
    for (int n = 0; n < 40; n++) begin
      rop = ops[$urandom_range(0, nops - 1)];
      rfw = $urandom_range(0, 3);
      rmw = $urandom_range(0, 3);
      rbt = 1'($urandom_range(0, 1));
      model(rop, rfw, rmw, rbt, e);
      run_instr(rop, rfw, rmw, rbt, m, ret);
      exp_ret = (exp_ret + 1) % RET_MOD;
      compare($sformatf("rnd%0d op=%b", n, rop), m, e, ret);
    end
    chk("random stream bus_error", int'(bus_error), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_multicycle_controller.md
Name: riscv_multicycle_controller

Overview:
Multi-cycle sequencer for the RV32I datapath. Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK and drives the datapath strobes: PC, IR, register file, ALU source, PC mux and memory request. It also handshakes with a shared instruction/data memory port and counts retired instructions. It sits between the instruction register/ALU compare outputs and the datapath enables.

Parameters:
MEM_TIMEOUT, 15, max cycles mem_req may stay high without mem_ready before bus error; 0 disables timeout
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
opcode  input  7  opcode field of instruction register; valid from DECODE onward
branch_taken  input  1  ALU compare result; sampled in EXECUTE for branches
mem_ready  input  1  memory completes current request this cycle
mem_req  output  1  memory request, held until mem_ready
mem_we  output  1  write qualifier; 1 only for store in MEM
ir_write  output  1  load instruction register
pc_write  output  1  load PC
pc_src  output  2  00 pc+4, 01 branch/jal target, 10 jalr target
alu_src  output  1  1 = immediate operand B
reg_write  output  1  register file write enable
instr_done  output  1  one-cycle pulse per retired instruction
retired  output  CNT_W  retired-instruction count
state_o  output  3  current state encoding, for debug
halted  output  1  controller in HALT
bus_error  output  1  sticky; memory timeout occurred

Behaviour:
- States: RST_IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, HALT=7.
- rst=1: state<=RST_IDLE, retired<=0, bus_error<=0, timeout counter<=0. All outputs 0 while in RST_IDLE. RST_IDLE->FETCH unconditionally on the next edge.
- rst asserted mid-operation (including mid-handshake or HALT) aborts the operation. No pending write completes after the reset edge.
- Outputs are decoded from the state register and the registered opcode only; they are not affected by the mem_ready input except where stated.
- FETCH: mem_req=1, mem_we=0. On mem_ready: ir_write=1, pc_write=1, pc_src=00, then ->DECODE. Without mem_ready, stay in FETCH.
- DECODE: one cycle, all strobes 0. Supported opcodes ->EXECUTE: 0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 0010111, 1101111, 1100111.
- Unsupported opcode in DECODE: treated as NOP. instr_done=1, ->FETCH.
- EXECUTE: alu_src=1 for all classes except R-type (0110011) and branch.
  - Branch: pc_write=branch_taken, pc_src=01, instr_done=1, ->FETCH.
  - Load/store: ->MEM.
  - All others: ->WRITEBACK.
- MEM: mem_req=1; mem_we=1 for store only. On mem_ready: load ->WRITEBACK; store: instr_done=1, ->FETCH.
- WRITEBACK: reg_write=1, instr_done=1, ->FETCH. JAL additionally drives pc_write=1, pc_src=01. JALR additionally drives pc_write=1, pc_src=10.
- Latency per instruction with zero-wait memory (FETCH..last state inclusive):
  - R/I/LUI/AUIPC/JAL/JALR: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - Each wait cycle adds 1.
- retired increments by 1 on every instr_done cycle and wraps modulo 2^CNT_W.
- Timeout counter:
  - Increments each cycle mem_req=1 and mem_ready=0; clears when mem_ready=1 or mem_req=0.
  - When the counter equals MEM_TIMEOUT (MEM_TIMEOUT>0): bus_error<=1, ->HALT.
  - mem_ready arriving on that same cycle wins: normal completion, no error.
- HALT: all strobes 0, halted=1. Exit only via rst.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: adds output illegal_instr (1 bit, sticky, reset 0). An unsupported opcode in DECODE sets illegal_instr, goes ->HALT, does not assert instr_done and does not increment retired.
- Undefined: no illegal_instr port; unsupported opcodes are NOPs as described above.

Test Plan:
- Reset then ADD (0110011), mem_ready=1 always -> states 1,2,3,5,1; reg_write high only in cycle 4; alu_src=0; retired=1.
- LW (0000011) with 2 wait cycles in MEM -> mem_req high 3 cycles in MEM, mem_we=0, reg_write in WRITEBACK, total 7 cycles.
- SW (0100011) -> mem_we=1 only in MEM, reg_write never asserted, retired increments on MEM completion.
- BEQ with branch_taken=1 then 0 -> pc_write=1/pc_src=01 in EXECUTE first; pc_write=0 second; each 3 cycles.
- JALR (1100111) -> WRITEBACK shows reg_write=1, pc_write=1, pc_src=10.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=15 -> bus_error=1 and halted=1 after 15 wait cycles. rst=1 for one cycle -> state 0, bus_error=0. Opcode 0001111 -> NOP retires (trap/HALT with ILLEGAL_TRAP_EN).
